// File: rtl/gray_conv_arb_pkg.sv
// rtl/gray_conv_arb_pkg.sv - shared types and widths for the gray converter arbiter
package gray_conv_arb_pkg;

    localparam int PIX_W  = 16;
    localparam int GRAY_W = 8;
    localparam int SRC_W  = 1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/gray_conv_arb_if.sv
// rtl/gray_conv_arb_if.sv - source, converter and gray result signals of the arbiter
// px_cnt0/px_cnt1/stats_clr exist only when GRAY_CONV_ARB_STATS_EN is defined.
interface gray_conv_arb_if;
    import gray_conv_arb_pkg::*;

    logic [PIX_W-1:0]  s0_pix;
    logic              s0_valid;
    logic              s0_eol;
    logic              s0_ready;
    logic [PIX_W-1:0]  s1_pix;
    logic              s1_valid;
    logic              s1_eol;
    logic              s1_ready;
    logic [PIX_W-1:0]  conv_rgb565;
    logic              conv_valid;
    logic [GRAY_W-1:0] conv_gray;
    logic              conv_gray_valid;
    logic [GRAY_W-1:0] gray_out;
    logic [SRC_W-1:0]  gray_src;
    logic              gray_valid;
    logic              busy;
`ifdef GRAY_CONV_ARB_STATS_EN
    logic [31:0]       px_cnt0;
    logic [31:0]       px_cnt1;
    logic              stats_clr;
`endif

    // slave: the arbiter itself; master: capture front-ends, converter and sink
    modport slave (
        input  s0_pix, s0_valid, s0_eol,
        input  s1_pix, s1_valid, s1_eol,
        input  conv_gray, conv_gray_valid,
        output s0_ready, s1_ready,
        output conv_rgb565, conv_valid,
        output gray_out, gray_src, gray_valid, busy
`ifdef GRAY_CONV_ARB_STATS_EN
        ,
        input  stats_clr,
        output px_cnt0, px_cnt1
`endif
    );

    modport master (
        output s0_pix, s0_valid, s0_eol,
        output s1_pix, s1_valid, s1_eol,
        output conv_gray, conv_gray_valid,
        input  s0_ready, s1_ready,
        input  conv_rgb565, conv_valid,
        input  gray_out, gray_src, gray_valid, busy
`ifdef GRAY_CONV_ARB_STATS_EN
        ,
        output stats_clr,
        input  px_cnt0, px_cnt1
`endif
    );

endinterface

// File: rtl/gray_tag_pipe.sv
// rtl/gray_tag_pipe.sv - LAT-deep valid/source-tag delay line matching the converter latency
module gray_tag_pipe
    import gray_conv_arb_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [SRC_W-1:0] in_tag,
    output logic             out_valid,
    output logic [SRC_W-1:0] out_tag
);

    logic [LAT-1:0]   v_sr;
    logic [SRC_W-1:0] t_sr [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sr <= '0;
            for (int i = 0; i < LAT; i++) begin
                t_sr[i] <= '0;
            end
        end else begin
            v_sr[0] <= in_valid;
            t_sr[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                v_sr[i] <= v_sr[i-1];
                t_sr[i] <= t_sr[i-1];
            end
        end
    end

    assign out_valid = v_sr[LAT-1];
    assign out_tag   = t_sr[LAT-1];

endmodule

// File: rtl/gray_conv_arb.sv
// rtl/gray_conv_arb.sv - round-robin line-burst arbiter sharing one RGB565-to-gray converter
// Optional per-source transfer counters: define GRAY_CONV_ARB_STATS_EN.
module gray_conv_arb
    import gray_conv_arb_pkg::*;
#(
    parameter int BURST_MAX = 1024,
    parameter int GAP_MAX   = 15,
    parameter int CONV_LAT  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_conv_arb_if.slave bus
);

    localparam int GAP_W = $clog2(GAP_MAX + 1) + 1;

    arb_state_t       state;
    logic             last_grant;
    logic [16:0]      beat_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [SRC_W-1:0] conv_src;
    logic             tag_valid;
    logic [SRC_W-1:0] tag_src;

    logic             granted;
    logic             cur_valid;
    logic             cur_eol;
    logic             oth_valid;
    logic             xfer0;
    logic             xfer1;
    logic             xfer;
    logic [16:0]      beat_nxt;
    logic [GAP_W-1:0] gap_nxt;
    logic             beat_hit;
    logic             gap_hit;
    logic             burst_end;

    // ready is a pure decode of the state register, never of the incoming valid
    assign bus.s0_ready = (state == ARB_GRANT0);
    assign bus.s1_ready = (state == ARB_GRANT1);
    assign granted      = (state == ARB_GRANT0) || (state == ARB_GRANT1);
    assign bus.busy     = granted;

    assign cur_valid = (state == ARB_GRANT1) ? bus.s1_valid : bus.s0_valid;
    assign cur_eol   = (state == ARB_GRANT1) ? bus.s1_eol   : bus.s0_eol;
    assign oth_valid = (state == ARB_GRANT1) ? bus.s0_valid : bus.s1_valid;

    assign xfer0 = bus.s0_valid && (state == ARB_GRANT0);
    assign xfer1 = bus.s1_valid && (state == ARB_GRANT1);
    assign xfer  = xfer0 || xfer1;

    assign beat_nxt  = beat_cnt + 17'd1;
    assign gap_nxt   = gap_cnt + GAP_W'(1);
    assign beat_hit  = xfer && (beat_nxt == 17'(BURST_MAX));
    assign gap_hit   = granted && !cur_valid && (gap_nxt == GAP_W'(GAP_MAX));
    assign burst_end = granted && ((xfer && cur_eol) || beat_hit || gap_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (bus.s0_valid && (!bus.s1_valid || last_grant)) begin
                        state <= ARB_GRANT0;
                    end else if (bus.s1_valid) begin
                        state <= ARB_GRANT1;
                    end
                end
                ARB_GRANT0, ARB_GRANT1: begin
                    if (burst_end) begin
                        last_grant <= (state == ARB_GRANT1);
                        beat_cnt   <= '0;
                        gap_cnt    <= '0;
                        // a waiting peer takes over on the very next cycle
                        if (oth_valid) begin
                            state <= (state == ARB_GRANT0) ? ARB_GRANT1 : ARB_GRANT0;
                        end else if (!cur_valid) begin
                            state <= ARB_IDLE;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_nxt;
                        gap_cnt  <= '0;
                    end else begin
                        gap_cnt <= gap_nxt;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.conv_rgb565 <= '0;
            bus.conv_valid  <= 1'b0;
            conv_src        <= '0;
            bus.gray_out    <= '0;
            bus.gray_src    <= '0;
            bus.gray_valid  <= 1'b0;
        end else begin
            bus.conv_valid <= xfer;
            if (xfer) begin
                bus.conv_rgb565 <= xfer1 ? bus.s1_pix : bus.s0_pix;
                conv_src        <= SRC_W'(xfer1);
            end
            bus.gray_out   <= bus.conv_gray;
            bus.gray_valid <= bus.conv_gray_valid;
            // an untagged converter result is passed through with source 0
            bus.gray_src   <= tag_valid ? tag_src : '0;
        end
    end

    gray_tag_pipe #(
        .LAT (CONV_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.conv_valid),
        .in_tag    (conv_src),
        .out_valid (tag_valid),
        .out_tag   (tag_src)
    );

`ifdef GRAY_CONV_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.px_cnt0 <= '0;
            bus.px_cnt1 <= '0;
        end else if (bus.stats_clr) begin
            bus.px_cnt0 <= '0;
            bus.px_cnt1 <= '0;
        end else begin
            if (xfer0) begin
                bus.px_cnt0 <= bus.px_cnt0 + 32'd1;
            end
            if (xfer1) begin
                bus.px_cnt1 <= bus.px_cnt1 + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_conv_arb.sv
// tb/tb_gray_conv_arb.sv - directed scoreboard bench for gray_conv_arb
`timescale 1ns/1ps
module tb_gray_conv_arb;

    typedef struct {
        logic [15:0] pix;
        logic        eol;
        int          gap;
    } px_t;

    typedef struct packed {
        logic       src;
        logic [7:0] gray;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   bad;
    int   k0;
    int   k1;

    px_t  q0[$];
    px_t  q1[$];
    exp_t sb[$];
    logic xsrc[$];
    int   xcyc[$];
    logic [15:0] xpix[$];
    logic gsrc[$];
    int   gcyc[$];

    gray_conv_arb_if ifc ();

    gray_conv_arb #(
        .BURST_MAX (4),
        .GAP_MAX   (3),
        .CONV_LAT  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gray_of(input logic [15:0] p);
        int r, g, b;
        r = {p[15:11], p[15:13]};
        g = {p[10:5], p[10:9]};
        b = {p[4:0], p[4:2]};
        return 8'((77 * r + 150 * g + 29 * b) >> 8);
    endfunction

    // leading 1 makes the packed value encode the sequence length too
    function automatic logic [63:0] pack(input logic q[$]);
        logic [63:0] v;
        v = 64'd1;
        foreach (q[i]) v = (v << 1) | 64'(q[i]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one-cycle-latency converter model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifc.conv_gray       <= 8'd0;
            ifc.conv_gray_valid <= 1'b0;
        end else begin
            ifc.conv_gray       <= gray_of(ifc.conv_rgb565);
            ifc.conv_gray_valid <= ifc.conv_valid;
        end
    end

    initial begin : drv0
        logic t;
        px_t  p;
        ifc.s0_valid = 1'b0; ifc.s0_pix = 16'd0; ifc.s0_eol = 1'b0;
        forever begin
            @(negedge clk);
            t = ifc.s0_valid && ifc.s0_ready;
            @(posedge clk);
            #1;
            if (t && q0.size() != 0) void'(q0.pop_front());
            if (q0.size() != 0 && q0[0].gap > 0) begin
                p = q0.pop_front(); p.gap = p.gap - 1; q0.push_front(p);
                ifc.s0_valid = 1'b0;
            end else if (q0.size() != 0) begin
                ifc.s0_valid = 1'b1; ifc.s0_pix = q0[0].pix; ifc.s0_eol = q0[0].eol;
            end else begin
                ifc.s0_valid = 1'b0; ifc.s0_eol = 1'b0;
            end
        end
    end

    initial begin : drv1
        logic t;
        px_t  p;
        ifc.s1_valid = 1'b0; ifc.s1_pix = 16'd0; ifc.s1_eol = 1'b0;
        forever begin
            @(negedge clk);
            t = ifc.s1_valid && ifc.s1_ready;
            @(posedge clk);
            #1;
            if (t && q1.size() != 0) void'(q1.pop_front());
            if (q1.size() != 0 && q1[0].gap > 0) begin
                p = q1.pop_front(); p.gap = p.gap - 1; q1.push_front(p);
                ifc.s1_valid = 1'b0;
            end else if (q1.size() != 0) begin
                ifc.s1_valid = 1'b1; ifc.s1_pix = q1[0].pix; ifc.s1_eol = q1[0].eol;
            end else begin
                ifc.s1_valid = 1'b0; ifc.s1_eol = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifc.s0_valid && ifc.s0_ready) begin
                xsrc.push_back(1'b0); xcyc.push_back(cyc); xpix.push_back(ifc.s0_pix);
                sb.push_back({1'b0, gray_of(ifc.s0_pix)});
            end
            if (ifc.s1_valid && ifc.s1_ready) begin
                xsrc.push_back(1'b1); xcyc.push_back(cyc); xpix.push_back(ifc.s1_pix);
                sb.push_back({1'b1, gray_of(ifc.s1_pix)});
            end
            if (ifc.gray_valid) begin
                gsrc.push_back(ifc.gray_src); gcyc.push_back(cyc);
                check("gray_has_tag", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("gray_result", 64'({ifc.gray_src, ifc.gray_out}), 64'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push_line(input int k, input int len, input logic [15:0] base,
                             input int gap_at, input int gap_len);
        px_t p;
        for (int i = 0; i < len; i++) begin
            p.pix = base + 16'(i) * 16'h0843;
            p.eol = (i == len - 1);
            p.gap = (i == gap_at) ? gap_len : 0;
            if (k == 0) q0.push_back(p); else q1.push_back(p);
        end
    endtask

    task automatic clear_logs();
        xsrc.delete(); xcyc.delete(); xpix.delete(); gsrc.delete(); gcyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q0.delete(); q1.delete(); sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (((q0.size() + q1.size() + sb.size()) != 0 || ifc.busy ||
                ifc.s0_valid || ifc.s1_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check(tag, 64'(w < 300), 64'd1);
    endtask

    initial begin : main
`ifdef GRAY_CONV_ARB_STATS_EN
        ifc.stats_clr = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({ifc.s0_ready, ifc.s1_ready, ifc.conv_valid, ifc.conv_rgb565,
              ifc.gray_out, ifc.gray_src, ifc.gray_valid, ifc.busy}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", 64'({ifc.busy, ifc.s0_ready, ifc.s1_ready}), 64'd0);

        // single source, one 4-pixel line
        clear_logs();
        push_line(0, 4, 16'h1234, -1, 0);
        drain("t1_drain");
        check("t1_gray_src_seq", pack(gsrc), 64'b1_0000);
        check("t1_latency", 64'((gcyc.size() != 0 && xcyc.size() != 0) ? gcyc[0] - xcyc[0] : -1), 64'd3);
        check("t1_back_to_idle", 64'({ifc.busy, ifc.s0_ready, ifc.s1_ready}), 64'd0);

        // simultaneous 3-pixel lines after reset
        do_reset();
        push_line(0, 3, 16'h2000, -1, 0);
        push_line(1, 3, 16'hA000, -1, 0);
        drain("t2_drain");
        check("t2_xfer_order", pack(xsrc), 64'b1_000_111);
        check("t2_gray_src_seq", pack(gsrc), 64'b1_000_111);
        check("t2_no_bubble", 64'((xcyc.size() >= 4) ? xcyc[3] - xcyc[2] : -1), 64'd1);

        // burst cap of 4 with a waiting peer
        do_reset();
        push_line(0, 10, 16'h3000, -1, 0);
        push_line(1, 3, 16'hB000, -1, 0);
        drain("t3_drain");
        check("t3_xfer_order", pack(xsrc), 64'b1_0000_111_0000_00);
        check("t3_gray_src_seq", pack(gsrc), 64'b1_0000_111_0000_00);
        bad = 0; k0 = 0; k1 = 0;
        foreach (xpix[i]) begin
            if (xsrc[i] == 1'b0) begin
                if (xpix[i] != 16'h3000 + 16'(k0) * 16'h0843) bad++;
                k0++;
            end else begin
                if (xpix[i] != 16'hB000 + 16'(k1) * 16'h0843) bad++;
                k1++;
            end
        end
        check("t3_pixel_integrity", 64'(bad), 64'd0);

        // s0 stalls 3 cycles mid-line while s1 waits
        do_reset();
        push_line(0, 4, 16'h4000, 2, 3);
        push_line(1, 3, 16'hC000, -1, 0);
        drain("t4_drain");
        check("t4_xfer_order", pack(xsrc), 64'b1_00_111_00);
        check("t4_switch_cycle", 64'((xcyc.size() >= 3) ? xcyc[2] - xcyc[1] : -1), 64'd4);

        // asynchronous reset in the middle of a burst
        do_reset();
        push_line(0, 5, 16'h5000, -1, 0);
        n = 0;
        while (xsrc.size() < 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_two_xfers", 64'(xsrc.size() >= 2), 64'd1);
        @(posedge clk);
        #2;
        check("t5_active_before_rst", 64'({ifc.busy, ifc.conv_valid}), 64'b11);
        rst_n = 1'b0;
        #1;
        check("t5_outputs_in_rst", 64'({ifc.s0_ready, ifc.s1_ready, ifc.conv_valid, ifc.conv_rgb565,
              ifc.gray_out, ifc.gray_src, ifc.gray_valid, ifc.busy}), 64'd0);
        q0.delete(); q1.delete(); sb.delete();
        clear_logs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        push_line(0, 3, 16'h6000, -1, 0);
        push_line(1, 3, 16'hD000, -1, 0);
        drain("t5_drain");
        check("t5_s0_first", pack(xsrc), 64'b1_000_111);

`ifdef GRAY_CONV_ARB_STATS_EN
        do_reset();
        check("t6_cnt_reset", 64'({ifc.px_cnt0, ifc.px_cnt1}), 64'd0);
        push_line(0, 7, 16'h0100, -1, 0);
        push_line(1, 5, 16'hE000, -1, 0);
        drain("t6_drain");
        check("t6_px_cnt0", 64'(ifc.px_cnt0), 64'd7);
        check("t6_px_cnt1", 64'(ifc.px_cnt1), 64'd5);
        push_line(0, 3, 16'h7000, -1, 0);
        n = 0;
        while (!(ifc.s0_valid && ifc.s0_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_found_xfer", 64'(n < 50), 64'd1);
        ifc.stats_clr = 1'b1;
        @(posedge clk);
        #1;
        ifc.stats_clr = 1'b0;
        check("t6_clr_priority", 64'({ifc.px_cnt0, ifc.px_cnt1}), 64'd0);
        drain("t6_drain2");
        check("t6_cnt_after_clr", 64'(ifc.px_cnt0), 64'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
